// File: rtl/ex_stage.sv
// ex_stage: 16-bit execute-stage ALU with Z/V/N flag register.
// Optional EX_FLAG_FWD_EN: combinational flags_fwd of next-edge flags.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  imm4,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] sh_in,
    output logic [3:0]  sh_shift,
    output logic [1:0]  sh_mode,
    input  logic [15:0] sh_out,
    output logic        valid_out,
    output logic [15:0] result,
    output logic [2:0]  flags,
    output logic [2:0]  flags_fwd
);

    logic [16:0] sum17;
    logic [16:0] dif17;
    logic        add_ov;
    logic        sub_ov;
    logic [15:0] add_sat;
    logic [15:0] sub_sat;
    logic [8:0]  red_hi;
    logic [8:0]  red_lo;
    logic [9:0]  red10;
    logic [15:0] pad;
    logic [15:0] alu_res;
    logic        zw;
    logic        vw;
    logic        nw;
    logic        ov;
    logic [2:0]  nflags;
    logic        accept;

    assign sh_in    = a;
    assign sh_shift = imm4;
    assign accept   = valid_in & ~flush & ~stall;

    // Shifter mode only for the three shift opcodes.
    always_comb begin
        sh_mode = 2'b00;
        if (opcode == 4'b0100 || opcode == 4'b0101 || opcode == 4'b0110)
            sh_mode = opcode[1:0];
    end

    assign sum17   = {a[15], a} + {b[15], b};
    assign dif17   = {a[15], a} - {b[15], b};
    assign add_ov  = sum17[16] ^ sum17[15];
    assign sub_ov  = dif17[16] ^ dif17[15];
    assign add_sat = add_ov ? (sum17[16] ? 16'h8000 : 16'h7fff)
                            : sum17[15:0];
    assign sub_sat = sub_ov ? (dif17[16] ? 16'h8000 : 16'h7fff)
                            : dif17[15:0];

    assign red_hi = {a[15], a[15:8]} + {b[15], b[15:8]};
    assign red_lo = {a[7], a[7:0]} + {b[7], b[7:0]};
    assign red10  = {red_hi[8], red_hi} + {red_lo[8], red_lo};

    // Four independent saturating signed nibble adds.
    always_comb begin
        logic [4:0] nib;
        nib = '0;
        pad = '0;
        for (int i = 0; i < 4; i++) begin
            nib = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
            if (nib[4] ^ nib[3])
                pad[4*i +: 4] = nib[4] ? 4'h8 : 4'h7;
            else
                pad[4*i +: 4] = nib[3:0];
        end
    end

    // Result select and per-flag write enables.
    always_comb begin
        alu_res = a;
        zw = 1'b0;
        vw = 1'b0;
        nw = 1'b0;
        ov = 1'b0;
        unique casez (opcode)
            4'b0000: begin
                alu_res = add_sat;
                zw = 1'b1;
                vw = 1'b1;
                nw = 1'b1;
                ov = add_ov;
            end
            4'b0001: begin
                alu_res = sub_sat;
                zw = 1'b1;
                vw = 1'b1;
                nw = 1'b1;
                ov = sub_ov;
            end
            4'b0010: begin
                alu_res = a ^ b;
                zw = 1'b1;
            end
            4'b0011: alu_res = {{6{red10[9]}}, red10};
            4'b0100, 4'b0101, 4'b0110: begin
                alu_res = sh_out;
                zw = 1'b1;
            end
            4'b0111: alu_res = pad;
            4'b1???: alu_res = a;
        endcase
    end

    assign nflags[2] = zw ? (alu_res == 16'h0000) : flags[2];
    assign nflags[1] = vw ? ov : flags[1];
    assign nflags[0] = nw ? alu_res[15] : flags[0];

`ifdef EX_FLAG_FWD_EN
    assign flags_fwd = accept ? nflags : flags;
`else
    assign flags_fwd = flags;
`endif

    // Pipeline register: flush kills, stall holds, accept writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= 16'h0000;
            flags     <= 3'b000;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!stall) begin
            valid_out <= valid_in;
            if (accept) begin
                result <= alu_res;
                flags  <= nflags;
            end
        end
    end

endmodule
